// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter sharing one free-running pipelined multiplier among NUM_REQ requesters.
// Define MULT_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority (the RR pointer is then removed).
module mult_rr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 16,
    parameter int PIPE_LAT = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*WIDTH-1:0]      req_a,
    input  logic [NUM_REQ*WIDTH-1:0]      req_b,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [2*WIDTH-1:0]            rsp_data,
    output logic                          mult_en,
    output logic [WIDTH-1:0]              mult_a,
    output logic [WIDTH-1:0]              mult_b,
    output logic                          mult_vld,
    input  logic [2*WIDTH-1:0]            mult_res,
    output logic [$clog2(PIPE_LAT+2)-1:0] inflight,
    output logic                          busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(PIPE_LAT+2);

    genvar gi;

    logic [WIDTH-1:0] op_a [NUM_REQ];
    logic [WIDTH-1:0] op_b [NUM_REQ];

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
            assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic            gnt_found;
    logic [ID_W-1:0] gnt_idx;
    logic            xfer;

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!gnt_found && req_valid[ID_W'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    // Search begins at the pointer and wraps; cand has one spare bit so the sum never overflows.
    always_comb begin
        logic [ID_W:0] cand;
        cand      = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!gnt_found && req_valid[cand[ID_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // No grant is offered while reset is held, so nothing is issued into a clearing pipeline.
    assign xfer = gnt_found & ~reset;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = xfer && (gnt_idx == ID_W'(gi));
        end
    endgenerate

    logic             mult_en_q;
    logic             mult_vld_q;
    logic [WIDTH-1:0] mult_a_q;
    logic [WIDTH-1:0] mult_a_d;
    logic [WIDTH-1:0] mult_b_q;
    logic [WIDTH-1:0] mult_b_d;
    logic [ID_W-1:0]  issue_id_q;
    logic [ID_W-1:0]  issue_id_d;

    always_comb begin
        mult_a_d   = mult_a_q;
        mult_b_d   = mult_b_q;
        issue_id_d = issue_id_q;
        if (xfer) begin
            mult_a_d   = op_a[gnt_idx];
            mult_b_d   = op_b[gnt_idx];
            issue_id_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mult_en_q  <= 1'b0;
            mult_vld_q <= 1'b0;
            mult_a_q   <= '0;
            mult_b_q   <= '0;
            issue_id_q <= '0;
        end else begin
            mult_en_q  <= 1'b1;
            mult_vld_q <= xfer;
            mult_a_q   <= mult_a_d;
            mult_b_q   <= mult_b_d;
            issue_id_q <= issue_id_d;
        end
    end

    assign mult_en  = mult_en_q;
    assign mult_vld = mult_vld_q;
    assign mult_a   = mult_a_q;
    assign mult_b   = mult_b_q;

    // Tag stage k is aligned with multiplier stage k; the tail lines up with mult_res.
    logic            tag_vld_q [PIPE_LAT];
    logic [ID_W-1:0] tag_id_q  [PIPE_LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < PIPE_LAT; k++) begin
                tag_vld_q[k] <= 1'b0;
                tag_id_q[k]  <= '0;
            end
        end else begin
            tag_vld_q[0] <= mult_vld_q;
            tag_id_q[0]  <= issue_id_q;
            for (int k = 1; k < PIPE_LAT; k++) begin
                tag_vld_q[k] <= tag_vld_q[k-1];
                tag_id_q[k]  <= tag_id_q[k-1];
            end
        end
    end

    logic            tail_vld;
    logic [ID_W-1:0] tail_id;
    logic            rsp_fire;

    assign tail_vld = tag_vld_q[PIPE_LAT-1];
    assign tail_id  = tag_id_q[PIPE_LAT-1];
    assign rsp_fire = tail_vld & ~reset;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = rsp_fire && (tail_id == ID_W'(gi));
        end
    endgenerate

    assign rsp_data = rsp_fire ? mult_res : '0;

    logic [CNT_W-1:0] inflight_q;
    logic [CNT_W-1:0] inflight_d;

    always_comb begin
        inflight_d = inflight_q;
        if (xfer && !tail_vld) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!xfer && tail_vld) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign inflight = inflight_q;
    assign busy     = (inflight_q != '0);

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Randomized self-checking bench for mult_rr_arbiter with a queue-based reference model
// and a behavioural pipelined multiplier standing in for the DSP.
module tb_mult_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int L  = 5;
    localparam int CW = $clog2(L+2);

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [2*W-1:0] rsp_data;
    logic           mult_en;
    logic [W-1:0]   mult_a;
    logic [W-1:0]   mult_b;
    logic           mult_vld;
    logic [2*W-1:0] mult_res;
    logic [CW-1:0]  inflight;
    logic           busy;

    logic [W-1:0] op_a [N];
    logic [W-1:0] op_b [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_pack
        assign req_a[gi*W +: W] = op_a[gi];
        assign req_b[gi*W +: W] = op_b[gi];
    end

    mult_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .PIPE_LAT(L)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .mult_en(mult_en), .mult_a(mult_a), .mult_b(mult_b), .mult_vld(mult_vld),
        .mult_res(mult_res), .inflight(inflight), .busy(busy)
    );

    always #5 clk = ~clk;

    // Free-running DSP model: product appears L cycles after the operands are sampled.
    logic [2*W-1:0] dsp_pipe [L];
    always @(posedge clk) begin
        if (mult_en) begin
            dsp_pipe[0] <= (2*W)'(mult_a) * (2*W)'(mult_b);
            for (int k = 1; k < L; k++) dsp_pipe[k] <= dsp_pipe[k-1];
        end
    end
    assign mult_res = dsp_pipe[L-1];

    typedef struct {
        int             due;
        int             id;
        logic [2*W-1:0] prod;
    } rsp_t;

    rsp_t         exp_q[$];
    logic [N-1:0] gnt_log[$];
    int           cyc;
    int           ptr_m;
    int           last_gnt;
    int           peak_infl;
    logic         exp_en;
    logic         exp_vld;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    int           tests;
    int           fails;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(3, 0))
            0:       return '1;
            1:       return '0;
            default: return W'($urandom);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid = req_valid | (N'(1) << i);
        op_a[i]   = a;
        op_b[i]   = b;
    endtask

    task automatic clr_req(input int i);
        req_valid = req_valid & ~(N'(1) << i);
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, then return after the edge.
    task automatic step();
        int             g;
        logic [N-1:0]   vshift;
        logic [N-1:0]   exp_rdy;
        logic [N-1:0]   exp_rv;
        logic [2*W-1:0] exp_rd;
        @(negedge clk);
        g = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
`ifdef MULT_ARB_FIXED_PRIO_EN
                int idx = k;
`else
                int idx = (ptr_m + k) % N;
`endif
                vshift = req_valid >> idx;
                if (g < 0 && vshift[0]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
        exp_rv  = '0;
        exp_rd  = '0;
        if (!reset && exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_rv = N'(1) << exp_q[0].id;
            exp_rd = exp_q[0].prod;
        end
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("rsp_data",  64'(rsp_data),  64'(exp_rd));
        check("mult_en",   64'(mult_en),   64'(exp_en));
        check("mult_vld",  64'(mult_vld),  64'(exp_vld));
        check("mult_a",    64'(mult_a),    64'(exp_a));
        check("mult_b",    64'(mult_b),    64'(exp_b));
        check("inflight",  64'(inflight),  64'(exp_q.size()));
        check("busy",      64'(busy),      64'(exp_q.size() != 0));
        if (int'(inflight) > peak_infl) peak_infl = int'(inflight);
        gnt_log.push_back(req_ready);
        if (exp_rv != '0) begin
            $display("[TB] cyc=%0d rsp id=%0d data=%0h", cyc, exp_q[0].id, rsp_data);
            void'(exp_q.pop_front());
        end
        if (reset) begin
            exp_q.delete();
            ptr_m   = 0;
            exp_en  = 1'b0;
            exp_vld = 1'b0;
            exp_a   = '0;
            exp_b   = '0;
        end else begin
            exp_en  = 1'b1;
            exp_vld = (g >= 0);
            if (g >= 0) begin
                exp_a = op_a[g];
                exp_b = op_b[g];
                exp_q.push_back('{due: cyc + 1 + L, id: g, prod: (2*W)'(exp_a) * (2*W)'(exp_b)});
                ptr_m = (g + 1) % N;
            end
        end
        last_gnt = g;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] e;
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        peak_infl = 0;
        last_gnt  = -1;
        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        @(posedge clk);
        #1;
        ptr_m   = 0;
        exp_en  = 1'b0;
        exp_vld = 1'b0;
        exp_a   = '0;
        exp_b   = '0;
        step();
        step();
        reset = 1'b0;

        // Idle after reset: mult_en rises, nothing else moves.
        idle(10);

        // All four requesters held: rotation, one response per cycle, inflight tops out at L+1.
        gnt_log.delete();
        peak_infl = 0;
        for (int i = 0; i < N; i++) set_req(i, W'(i + 1), W'(10));
        repeat (8) step();
        for (int k = 0; k < 8; k++) begin
            e = '0;
`ifdef MULT_ARB_FIXED_PRIO_EN
            e[0] = 1'b1;
`else
            e = N'(1) << (k % N);
`endif
            check("rr_order", 64'(gnt_log[k]), 64'(e));
        end
        idle(L + 3);
        check("infl_peak", 64'(peak_infl), 64'(L + 1));

        // Single requester 0: 3*7.
        set_req(0, W'(3), W'(7));
        step();
        idle(L + 3);

        // Largest operands from requester 2.
        set_req(2, 16'hFFFF, 16'hFFFF);
        step();
        idle(L + 3);

        // Three back-to-back issues, then reset discards them; next grant restarts at requester 0.
        for (int i = 0; i < 3; i++) set_req(i, rand_op(), rand_op());
        repeat (3) begin
            step();
            if (last_gnt >= 0) clr_req(last_gnt);
        end
        idle(2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(L + 5);
        for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
        step();
        check("post_rst_gnt", 64'(gnt_log[gnt_log.size() - 1]), 64'(4'b0001));
        idle(L + 3);

        // Requesters 1 and 3 held together.
        set_req(1, W'(5), W'(6));
        set_req(3, W'(7), W'(8));
        repeat (6) step();
        idle(L + 3);

        // Random traffic with a reset in the middle.
        for (int it = 0; it < 400; it++) begin
            if (it == 200) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            step();
            for (int i = 0; i < N; i++) begin
                if (last_gnt == i) begin
                    if ($urandom_range(1, 0) == 0) clr_req(i);
                    else set_req(i, rand_op(), rand_op());
                end else if (((req_valid >> i) & N'(1)) == '0 && $urandom_range(3, 0) == 0) begin
                    set_req(i, rand_op(), rand_op());
                end
            end
        end
        idle(L + 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
